// File: rtl/dff_input_conditioner.sv
// Conditions three raw bouncing switches (data, set, clear) for the clear/set D flip-flop:
// synchronize, debounce, and turn set/clear presses into one-cycle active-low strobes.
module dff_input_conditioner #(
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sw_d,
    input  logic       sw_set,
    input  logic       sw_clr,
    output logic       d,
    output logic       set,
    output logic       clr,
    output logic [7:0] evt_cnt
);

    localparam int CH_D   = 0;
    localparam int CH_SET = 1;
    localparam int CH_CLR = 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [2:0]       sw_raw;
    logic [2:0]       s1;
    logic [2:0]       s2;
    logic [2:0]       db;
    logic [CNT_W-1:0] cnt [3];
    logic             set_rise;
    logic             clr_rise;

    assign sw_raw = {sw_clr, sw_set, sw_d};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= sw_raw;
            s2 <= s1;
        end
    end

    // Any cycle where the synchronized input agrees with the debounced state discards progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (s2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    db[i]  <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        set_rise = !db[CH_SET] && s2[CH_SET] && (cnt[CH_SET] == CNT_LAST);
        clr_rise = !db[CH_CLR] && s2[CH_CLR] && (cnt[CH_CLR] == CNT_LAST);
    end

    // Clear wins a same-edge collision; the set press is dropped rather than deferred.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            set     <= 1'b1;
            clr     <= 1'b1;
            evt_cnt <= 8'd0;
        end else begin
            set <= !(set_rise && !clr_rise);
            clr <= !clr_rise;
            if (set_rise || clr_rise) begin
                evt_cnt <= evt_cnt + 8'd1;
            end
        end
    end

    assign d = db[CH_D];

endmodule

// File: doc/dff_input_conditioner.md
# dff_input_conditioner

Upstream stage for the synchronous active-low clear/set D flip-flop. Takes three raw, asynchronous, bouncing switch inputs (data, set, clear), synchronizes and debounces each, and drives the flop's `d`, `set` and `clr` inputs. The debounced data switch drives `d` as a clean level. Debounced set and clear presses become single-cycle, registered, active-low strobes that the flop samples on the next rising edge. An accepted-event counter supports bench checking.

## Interface
- `DB_CYCLES`, default 4: consecutive cycles a synchronized input must differ from its debounced state before the state flips. Legal range ≥ 2.
- `CNT_W`, default 3: debounce counter width. Must hold `DB_CYCLES-1`.
- `clk`  in  1  single system clock. All logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low. Deasserts synchronously to `clk` (external).
- `sw_d`  in  1  raw data switch. Asynchronous, active-high.
- `sw_set`  in  1  raw set push-button. Asynchronous, active-high (pressed = 1).
- `sw_clr`  in  1  raw clear push-button. Asynchronous, active-high.
- `d`  out  1  debounced data level, registered.
- `set`  out  1  active-low one-cycle set strobe, registered.
- `clr`  out  1  active-low one-cycle clear strobe, registered.
- `evt_cnt`  out  8  count of strobes issued. Wraps 255 → 0.

## Operation
- Three identical channels. Each channel has:
  - a 2-flop synchronizer (`s1`, then `s2`);
  - a debounced state bit `db`;
  - a counter `cnt[CNT_W-1:0]`.
- Per channel, each edge:
  - If `s2 == db`: `cnt` ← 0.
  - Else if `cnt == DB_CYCLES-1`: `db` ← `s2` and `cnt` ← 0.
  - Else: `cnt` ← `cnt+1`.
- A single cycle with `s2 == db` discards all counting progress. Bounces shorter than `DB_CYCLES` cycles are rejected.
- Output `d` is the data channel's `db`, wired straight through (already registered).
- Press detect: the rise event is the edge where `db` goes 0→1 for the set or clear channel.
  - On that same edge, the corresponding `set`/`clr` register is driven to 0.
  - On the following edge it returns to 1.
  - A strobe is exactly one cycle low.
  - Release (1→0) produces no strobe.
- Simultaneous rise events on set and clear at the same edge:
  - `clr` ← 0 and `set` stays 1.
  - The set event is dropped, not deferred.
- `evt_cnt` increments by 1 on every edge that drives a strobe low. At most one strobe is issued per edge.
- A held button produces exactly one strobe per debounced press.

## Timing
- Reset values (asynchronous, while `rst_n`=0):
  - `s1`, `s2`, `db`, `cnt` all 0 on every channel;
  - `d`=0, `set`=1, `clr`=1, `evt_cnt`=0.
- Latency: a raw level that is stable from before rising edge E1 appears on `db`, `d`, and the strobe at edge E(DB_CYCLES+2).
  - With the default 4, that is 6 edges.
  - Breakdown: `s1` at E1, `s2` at E2, `cnt` counts at E3..E(DB_CYCLES+1), flip at E(DB_CYCLES+2).
- The strobe is low for the cycle between E(DB_CYCLES+2) and E(DB_CYCLES+3). The downstream flop samples it at E(DB_CYCLES+3).
- Minimum spacing between strobes on one channel: 2·DB_CYCLES cycles (a press, then a full debounced release).
- Reset mid-debounce or mid-strobe:
  - All progress is lost and `set`/`clr` return to 1 immediately.
  - A button still held when reset releases counts as a new press and strobes DB_CYCLES+2 edges later.
- Glitches on `sw_*` with metastable width are absorbed by the synchronizer. There is no combinational path from `sw_*` to any output.

## Test plan
- Reset check: assert `rst_n`=0 mid-cycle with all switches high -> outputs immediately `d`=0, `set`=1, `clr`=1, `evt_cnt`=0.
- Clean data switch, `DB_CYCLES`=4: `sw_d` 0→1 held steady -> `d`=1 exactly at the 6th rising edge after the change, with no strobes and `evt_cnt` unchanged.
- Bounce rejection: toggle `sw_set` high 3 cycles, low 1, high 3, low -> `set` stays 1 and `evt_cnt`=0. Then hold high 10 cycles -> exactly one `set`=0 cycle, `evt_cnt`=1.
- Held button: hold `sw_clr`=1 for 50 cycles, then release for 10 -> exactly one `clr`=0 pulse, 6 edges after the press. No pulse on release. `evt_cnt`=1.
- Simultaneous press: raise `sw_set` and `sw_clr` in the same cycle -> `clr`=0 for one cycle, `set` stays 1, `evt_cnt` +1. Connecting to the downstream flop gives `q`=0 and `q_cmp`=1.
- Wrap and reset-during-hold:
  - Issue 256 clear presses -> `evt_cnt` returns to 0.
  - Pulse `rst_n` low while `sw_set` is held -> one new `set` strobe 6 edges after reset release, and `evt_cnt`=1.
